// File: rtl/fx_slv_pkg.sv
// Shared constants for the fx bus responder: address field widths and register offsets.
package fx_slv_pkg;

  localparam int PAGE_W = 2;
  localparam int ID_W   = 6;
  localparam int OFS_W  = 8;

  localparam logic [OFS_W-1:0] OFS_ID         = 8'h00;
  localparam logic [OFS_W-1:0] OFS_SCRATCH    = 8'h01;
  localparam logic [OFS_W-1:0] OFS_CTRL0      = 8'h02;
  localparam logic [OFS_W-1:0] OFS_CNT_LO     = 8'h10;
  localparam logic [OFS_W-1:0] OFS_CNT_HI     = 8'h11;
  localparam logic [OFS_W-1:0] OFS_CNT_CLR    = 8'h12;
  localparam logic [OFS_W-1:0] OFS_FIFO_DATA  = 8'h20;
  localparam logic [OFS_W-1:0] OFS_FIFO_LEVEL = 8'h21;
  localparam logic [OFS_W-1:0] OFS_FIFO_STAT  = 8'h22;

endpackage

// File: rtl/fx_slv_fifo.sv
// Synchronous byte FIFO drained over the fx bus; drops pushes when full and flags them.
module fx_slv_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          ovf_set
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  // A pop frees a slot in the same cycle, so a push against a full FIFO that is also popped is kept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_set = push && !do_push;

  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fx_slave_regs.sv
// fx bus responder: control bank, event counter and drainable byte FIFO.
// Define FX_SLV_WR_ECHO_EN to echo written data on fx_q one cycle after each write hit.
module fx_slave_regs
  import fx_slv_pkg::*;
#(
  parameter logic [5:0] MOD_ID   = 6'h01,
  parameter int         NUM_CTRL = 8,
  parameter int         FIFO_AW  = 4,
  parameter logic [7:0] ID_VAL   = 8'hA5
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [15:0]           fx_waddr,
  input  logic                  fx_wr,
  input  logic [7:0]            fx_data,
  input  logic                  fx_rd,
  input  logic [15:0]           fx_raddr,
  output logic [7:0]            fx_q,
  output logic [8*NUM_CTRL-1:0] ctrl_bus,
  input  logic                  ev_pulse,
  input  logic [7:0]            fifo_wdata,
  input  logic                  fifo_wr,
  output logic                  fifo_full
);

  logic              wr_hit;
  logic              rd_hit;
  logic [OFS_W-1:0]  wofs;
  logic [OFS_W-1:0]  rofs;
  logic [7:0]        scratch;
  logic [7:0]        ctrl [NUM_CTRL];
  logic [15:0]       cnt;
  logic [7:0]        hi_snap;
  logic              ovf;
  logic [7:0]        rdata;
  logic [7:0]        q_next;
  logic [7:0]        fifo_rdata;
  logic [FIFO_AW:0]  fifo_level;
  logic              fifo_empty;
  logic              fifo_ovf_set;
  logic              fifo_pop;
  logic              cnt_clr;
  logic              stat_rd;

  assign wr_hit = fx_wr && (fx_waddr[15 -: PAGE_W] == '0) && (fx_waddr[OFS_W +: ID_W] == MOD_ID);
  assign rd_hit = fx_rd && (fx_raddr[15 -: PAGE_W] == '0) && (fx_raddr[OFS_W +: ID_W] == MOD_ID);
  assign wofs   = fx_waddr[OFS_W-1:0];
  assign rofs   = fx_raddr[OFS_W-1:0];

  assign fifo_pop = rd_hit && (rofs == OFS_FIFO_DATA);
  assign stat_rd  = rd_hit && (rofs == OFS_FIFO_STAT);
  assign cnt_clr  = wr_hit && (wofs == OFS_CNT_CLR);

  fx_slv_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .push    (fifo_wr),
    .wdata   (fifo_wdata),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ovf_set (fifo_ovf_set)
  );

  genvar g;
  generate
    for (g = 0; g < NUM_CTRL; g++) begin : g_ctrl_bus
      assign ctrl_bus[8*g +: 8] = ctrl[g];
    end
  endgenerate

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= '0;
      for (int n = 0; n < NUM_CTRL; n++) ctrl[n] <= '0;
    end else if (wr_hit) begin
      if (wofs == OFS_SCRATCH) scratch <= fx_data;
      for (int n = 0; n < NUM_CTRL; n++) begin
        if (wofs == OFS_CTRL0 + 8'(n)) ctrl[n] <= fx_data;
      end
    end
  end

  // Clear beats a coincident event; the high-byte snapshot lets the host read a coherent 16-bit value.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      hi_snap <= '0;
    end else begin
      if (cnt_clr)       cnt <= '0;
      else if (ev_pulse) cnt <= cnt + 16'd1;
      if (rd_hit && (rofs == OFS_CNT_LO)) hi_snap <= cnt[15:8];
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)            ovf <= 1'b0;
    else if (fifo_ovf_set) ovf <= 1'b1;
    else if (stat_rd)      ovf <= 1'b0;
  end

  always_comb begin
    rdata = '0;
    case (rofs)
      OFS_ID:         rdata = ID_VAL;
      OFS_SCRATCH:    rdata = scratch;
      OFS_CNT_LO:     rdata = cnt[7:0];
      OFS_CNT_HI:     rdata = hi_snap;
      OFS_FIFO_DATA:  rdata = fifo_rdata;
      OFS_FIFO_LEVEL: rdata = 8'(fifo_level);
      OFS_FIFO_STAT:  rdata = {5'b0, ovf, fifo_full, fifo_empty};
      default: begin
        for (int n = 0; n < NUM_CTRL; n++) begin
          if (rofs == OFS_CTRL0 + 8'(n)) rdata = ctrl[n];
        end
      end
    endcase
  end

  // fx_q is ORed with other slaves on the bus, so it must be zero unless answering this module.
  always_comb begin
    q_next = rd_hit ? rdata : 8'h00;
`ifdef FX_SLV_WR_ECHO_EN
    if (wr_hit) q_next = q_next | fx_data;
`endif
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) fx_q <= '0;
    else        fx_q <= q_next;
  end

endmodule

// File: tb/tb_fx_slave_regs.sv
// Directed self-checking bench for fx_slave_regs (default 8 ctrl regs, 16-deep FIFO, MOD_ID 1).
module tb_fx_slave_regs;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fx_waddr = '0;
  logic        fx_wr = 1'b0;
  logic [7:0]  fx_data = '0;
  logic        fx_rd = 1'b0;
  logic [15:0] fx_raddr = '0;
  logic [7:0]  fx_q;
  logic [63:0] ctrl_bus;
  logic        ev_pulse = 1'b0;
  logic [7:0]  fifo_wdata = '0;
  logic        fifo_wr = 1'b0;
  logic        fifo_full;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  fx_slave_regs dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .fx_waddr   (fx_waddr),
    .fx_wr      (fx_wr),
    .fx_data    (fx_data),
    .fx_rd      (fx_rd),
    .fx_raddr   (fx_raddr),
    .fx_q       (fx_q),
    .ctrl_bus   (ctrl_bus),
    .ev_pulse   (ev_pulse),
    .fifo_wdata (fifo_wdata),
    .fifo_wr    (fifo_wr),
    .fifo_full  (fifo_full)
  );

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, output logic [7:0] ack);
    @(negedge clk_sys);
    fx_waddr = a; fx_data = d; fx_wr = 1'b1;
    @(negedge clk_sys);
    fx_wr = 1'b0;
    ack = fx_q;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk_sys);
    fx_raddr = a; fx_rd = 1'b1;
    @(negedge clk_sys);
    fx_rd = 1'b0;
    d = fx_q;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (fx_q !== 8'h00) begin n_err++; $display("[TB] FAIL reset_fx_q got=%h exp=00", fx_q); end
    n_cmp++; if (ctrl_bus !== 64'h0) begin n_err++; $display("[TB] FAIL reset_ctrl got=%h exp=0", ctrl_bus); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("[TB] FAIL reset_full got=%b exp=0", fifo_full); end
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  task automatic test_id_read;
    logic [7:0] d;
    bus_read(16'h0100, d);
    n_cmp++; if (d !== 8'hA5) begin n_err++; $display("[TB] FAIL id_read got=%h exp=a5", d); end
    @(negedge clk_sys);
    n_cmp++; if (fx_q !== 8'h00) begin n_err++; $display("[TB] FAIL id_hold got=%h exp=00", fx_q); end
  endtask

  task automatic test_ctrl;
    logic [7:0] d;
    logic [7:0] ack;
    bus_write(16'h0103, 8'h3C, ack);
    n_cmp++; if (ctrl_bus[15:8] !== 8'h3C) begin n_err++; $display("[TB] FAIL ctrl1_bus got=%h exp=3c", ctrl_bus[15:8]); end
    bus_read(16'h0103, d);
    n_cmp++; if (d !== 8'h3C) begin n_err++; $display("[TB] FAIL ctrl1_read got=%h exp=3c", d); end
    bus_write(16'h0203, 8'h77, ack);
    n_cmp++; if (ctrl_bus !== 64'h0000_0000_0000_3C00) begin n_err++; $display("[TB] FAIL other_id_wr got=%h exp=3c00", ctrl_bus); end
    bus_read(16'h0203, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("[TB] FAIL other_id_rd got=%h exp=00", d); end
    bus_write(16'h0109, 8'h81, ack);
    n_cmp++; if (ctrl_bus[63:56] !== 8'h81) begin n_err++; $display("[TB] FAIL ctrl7_bus got=%h exp=81", ctrl_bus[63:56]); end
    bus_write(16'h010A, 8'hFF, ack);
    bus_write(16'h0100, 8'h11, ack);
    n_cmp++; if (ctrl_bus !== 64'h8100_0000_0000_3C00) begin n_err++; $display("[TB] FAIL unmapped_wr got=%h exp=8100000000003c00", ctrl_bus); end
    bus_read(16'h0100, d);
    n_cmp++; if (d !== 8'hA5) begin n_err++; $display("[TB] FAIL id_ro got=%h exp=a5", d); end
    bus_write(16'h0101, 8'hC3, ack);
    bus_read(16'h0101, d);
    n_cmp++; if (d !== 8'hC3) begin n_err++; $display("[TB] FAIL scratch got=%h exp=c3", d); end
    bus_read(16'h010A, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("[TB] FAIL unmapped_rd got=%h exp=00", d); end
  endtask

  task automatic test_counter;
    logic [7:0] d;
    logic [7:0] ack;
    @(negedge clk_sys);
    ev_pulse = 1'b1;
    repeat (32'h10004) @(negedge clk_sys);
    // The CNT_LO read samples the count before the 0x10005th pulse lands.
    fx_raddr = 16'h0110; fx_rd = 1'b1;
    @(negedge clk_sys);
    ev_pulse = 1'b0; fx_rd = 1'b0;
    n_cmp++; if (fx_q !== 8'h04) begin n_err++; $display("[TB] FAIL cnt_lo_wrap got=%h exp=04", fx_q); end
    bus_read(16'h0111, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("[TB] FAIL cnt_hi_wrap got=%h exp=00", d); end
    bus_read(16'h0110, d);
    n_cmp++; if (d !== 8'h05) begin n_err++; $display("[TB] FAIL cnt_lo_after got=%h exp=05", d); end
    @(negedge clk_sys);
    fx_waddr = 16'h0112; fx_data = 8'h00; fx_wr = 1'b1; ev_pulse = 1'b1;
    @(negedge clk_sys);
    fx_wr = 1'b0; ev_pulse = 1'b0;
    bus_read(16'h0110, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("[TB] FAIL cnt_clr_wins got=%h exp=00", d); end
    bus_write(16'h0110, 8'h55, ack);
    bus_read(16'h0110, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("[TB] FAIL cnt_ro got=%h exp=00", d); end
  endtask

  task automatic test_fifo;
    logic [7:0] d;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_sys);
      fifo_wdata = 8'h10 + 8'(i); fifo_wr = 1'b1;
    end
    @(negedge clk_sys);
    fifo_wr = 1'b0;
    n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("[TB] FAIL fifo_full got=%b exp=1", fifo_full); end
    bus_read(16'h0121, d);
    n_cmp++; if (d !== 8'h10) begin n_err++; $display("[TB] FAIL fifo_level16 got=%h exp=10", d); end
    bus_read(16'h0122, d);
    n_cmp++; if (d !== 8'h06) begin n_err++; $display("[TB] FAIL stat_ovf got=%h exp=06", d); end
    bus_read(16'h0122, d);
    n_cmp++; if (d !== 8'h02) begin n_err++; $display("[TB] FAIL stat_clr got=%h exp=02", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(16'h0120, d);
      n_cmp++; if (d !== 8'h10 + 8'(i)) begin n_err++; $display("[TB] FAIL fifo_pop%0d got=%h exp=%h", i, d, 8'h10 + 8'(i)); end
    end
    bus_read(16'h0120, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("[TB] FAIL pop_empty got=%h exp=00", d); end
    bus_read(16'h0122, d);
    n_cmp++; if (d !== 8'h01) begin n_err++; $display("[TB] FAIL stat_empty got=%h exp=01", d); end
  endtask

  task automatic test_simultaneous;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_sys);
      fifo_wdata = 8'h40 + 8'(i); fifo_wr = 1'b1;
    end
    @(negedge clk_sys);
    fifo_wdata = 8'hEE; fifo_wr = 1'b1;
    fx_raddr = 16'h0120; fx_rd = 1'b1;
    @(negedge clk_sys);
    fifo_wr = 1'b0; fx_rd = 1'b0;
    n_cmp++; if (fx_q !== 8'h40) begin n_err++; $display("[TB] FAIL full_pushpop got=%h exp=40", fx_q); end
    bus_read(16'h0121, d);
    n_cmp++; if (d !== 8'h10) begin n_err++; $display("[TB] FAIL full_level got=%h exp=10", d); end
    // A dropped push coinciding with a STAT read: read shows old ovf, ovf stays set.
    @(negedge clk_sys);
    fifo_wdata = 8'hDD; fifo_wr = 1'b1;
    fx_raddr = 16'h0122; fx_rd = 1'b1;
    @(negedge clk_sys);
    fifo_wr = 1'b0; fx_rd = 1'b0;
    n_cmp++; if (fx_q !== 8'h02) begin n_err++; $display("[TB] FAIL ovf_race_rd got=%h exp=02", fx_q); end
    bus_read(16'h0122, d);
    n_cmp++; if (d !== 8'h06) begin n_err++; $display("[TB] FAIL ovf_set_wins got=%h exp=06", d); end
    for (int i = 1; i < 16; i++) begin
      bus_read(16'h0120, d);
      n_cmp++; if (d !== 8'h40 + 8'(i)) begin n_err++; $display("[TB] FAIL drain%0d got=%h exp=%h", i, d, 8'h40 + 8'(i)); end
    end
    bus_read(16'h0120, d);
    n_cmp++; if (d !== 8'hEE) begin n_err++; $display("[TB] FAIL drain_last got=%h exp=ee", d); end
    @(negedge clk_sys);
    fifo_wdata = 8'h99; fifo_wr = 1'b1;
    fx_raddr = 16'h0120; fx_rd = 1'b1;
    @(negedge clk_sys);
    fifo_wr = 1'b0; fx_rd = 1'b0;
    n_cmp++; if (fx_q !== 8'h00) begin n_err++; $display("[TB] FAIL empty_pushpop got=%h exp=00", fx_q); end
    bus_read(16'h0121, d);
    n_cmp++; if (d !== 8'h01) begin n_err++; $display("[TB] FAIL empty_level got=%h exp=01", d); end
    bus_read(16'h0120, d);
    n_cmp++; if (d !== 8'h99) begin n_err++; $display("[TB] FAIL empty_stored got=%h exp=99", d); end
  endtask

  task automatic test_echo;
    logic [7:0] ack;
    logic [7:0] exp_ack;
`ifdef FX_SLV_WR_ECHO_EN
    exp_ack = 8'h5A;
`else
    exp_ack = 8'h00;
`endif
    bus_write(16'h0101, 8'h5A, ack);
    n_cmp++; if (ack !== exp_ack) begin n_err++; $display("[TB] FAIL wr_echo got=%h exp=%h", ack, exp_ack); end
    @(negedge clk_sys);
    n_cmp++; if (fx_q !== 8'h00) begin n_err++; $display("[TB] FAIL echo_hold got=%h exp=00", fx_q); end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk_sys);
    fx_raddr = 16'h0100; fx_rd = 1'b1;
    @(posedge clk_sys);
    #1;
    fx_rd = 1'b0;
    n_cmp++; if (fx_q !== 8'hA5) begin n_err++; $display("[TB] FAIL pre_reset_q got=%h exp=a5", fx_q); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (fx_q !== 8'h00) begin n_err++; $display("[TB] FAIL mid_reset_q got=%h exp=00", fx_q); end
    n_cmp++; if (ctrl_bus !== 64'h0) begin n_err++; $display("[TB] FAIL mid_reset_ctrl got=%h exp=0", ctrl_bus); end
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_ctrl();
    test_counter();
    test_fifo();
    test_simultaneous();
    test_echo();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fx_slave_regs.md
Name: fx_slave_regs

Overview:
- Responder end of the fx bus: decodes write and read cycles addressed to its own module ID and returns read data on fx_q.
- Holds a control register bank, a 16-bit event counter and a byte FIFO that the host drains over the bus.
- Several instances hang off one fx bus, and the bus controller ORs their fx_q. A slave therefore drives fx_q = 0 whenever it is not answering a cycle addressed to it.

Parameters:
- MOD_ID, 6'h01, module ID matched against address bits [13:8].
- NUM_CTRL, 8, number of 8-bit control registers (1..8).
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.
- ID_VAL, 8'hA5, constant returned at offset 0x00.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- fx_waddr  in  16  write address {2'b00, mod_id[5:0], offset[7:0]}.
- fx_wr  in  1  single-cycle write strobe.
- fx_data  in  8  write data, valid with fx_wr.
- fx_rd  in  1  single-cycle read strobe.
- fx_raddr  in  16  read address, same format as fx_waddr.
- fx_q  out  8  registered read/ack data.
- ctrl_bus  out  8*NUM_CTRL  control registers; reg n at bits [8n+7:8n].
- ev_pulse  in  1  event strobe; increments the event counter.
- fifo_wdata  in  8  FIFO push data.
- fifo_wr  in  1  FIFO push strobe.
- fifo_full  out  1  FIFO full flag.

Behaviour:
- Clock and reset: clk_sys, rst_n (asynchronous, active-low). All state is clocked by clk_sys and reset asynchronously by rst_n.
- Address hit: a write hits when fx_wr=1, fx_waddr[15:14]=0 and fx_waddr[13:8]=MOD_ID; a read hits under the same rule applied to fx_rd/fx_raddr. Non-hit cycles cause no state change.
- Offset map (low byte):
  - 0x00 ID: RO, reads ID_VAL.
  - 0x01 scratch: RW.
  - 0x02..0x02+NUM_CTRL-1 ctrl[n]: RW.
  - 0x10 CNT_LO: RO; a read also snapshots CNT[15:8] into hi_snap.
  - 0x11 CNT_HI: RO, returns hi_snap.
  - 0x12 CNT_CLR: WO; any write clears CNT.
  - 0x20 FIFO_DATA: RO; a read pops one entry.
  - 0x21 FIFO_LEVEL: RO, occupancy 0..depth.
  - 0x22 FIFO_STAT: RO, {5'b0, ovf, full, empty}; a read clears ovf.
  - Writes to RO/unmapped offsets are ignored. Reads of WO/unmapped offsets return 0x00.
- Read latency: read data appears on fx_q exactly 1 cycle after the fx_rd hit and is held for that single cycle only. fx_q = 0 in every other cycle (but see the optional feature for write cycles).
- Writes take effect on the clock edge at which the fx_wr hit is sampled; a read of the same register one cycle later returns the new value.
- Event counter:
  - 16-bit, increments on ev_pulse and wraps 0xFFFF -> 0x0000.
  - A CNT_CLR write in the same cycle as ev_pulse leaves CNT = 0 (clear wins).
- FIFO:
  - Push on fifo_wr when not full. A push while full is dropped and sets sticky ovf.
  - Pop on a FIFO_DATA read hit. Popping when empty returns 0x00 and leaves pointers unchanged.
  - Simultaneous push and pop when not empty and not full: both occur, level unchanged.
  - When full: the pop occurs and the push is accepted (no ovf).
  - When empty: the pop returns 0x00 and the push is stored.
  - Pointers wrap modulo depth; level is FIFO_AW+1 bits wide.
  - fifo_full is combinational from level.
- ovf clear vs. set: if an ovf-setting drop coincides with a FIFO_STAT read, the read returns the old ovf and ovf stays 1 (set wins).
- fx_rd and fx_wr never assert in the same cycle. If they do, both are serviced independently.
- Reset values: fx_q=0, ctrl_bus=0, scratch=0, CNT=0, hi_snap=0, FIFO empty, ovf=0, fifo_full=0.
- Reset mid-operation clears all state immediately; a pending read response is discarded.

Optional Feature:
- FX_SLV_WR_ECHO_EN defined: 1 cycle after a write hit, fx_q carries the written fx_data (echo acknowledge), including writes to RO/unmapped offsets.
- Undefined: fx_q = 0 after writes.

Decomposition:
- Package fx_slv_pkg holds offset constants (OFS_ID, OFS_SCRATCH, OFS_CTRL0, OFS_CNT_LO, OFS_CNT_HI, OFS_CNT_CLR, OFS_FIFO_DATA, OFS_FIFO_LEVEL, OFS_FIFO_STAT) and the address-split field widths.
- Sub-module fx_slv_fifo: parameterised synchronous FIFO with push/pop, level, full/empty, drop-on-full and an ovf-set pulse output.

Test Plan:
- Reset, then read 0x00 with MOD_ID=1 (raddr 16'h0100) -> fx_q=0xA5 one cycle after fx_rd; 0x00 in all other cycles.
- Write 0x3C to 16'h0103, then read it back -> ctrl_bus[15:8]=0x3C; readback 0x3C. The same write to 16'h0203 (other ID) -> no change; a read of 16'h0203 returns 0x00.
- 0x1_0005 ev_pulses, read CNT_LO then CNT_HI -> 0x04, then 0x00 (wrapped). Then CNT_CLR write together with ev_pulse -> CNT_LO reads 0x00.
- Push 17 bytes into the 16-deep FIFO -> fifo_full=1, LEVEL=16, STAT=0x06. A second STAT read -> 0x02. Pop 16 -> first 16 bytes in order. Pop on empty -> 0x00.
- Simultaneous push and pop with level=16 -> level stays 16, no ovf; with level=0 -> pop returns 0x00, level becomes 1.
- Build with FX_SLV_WR_ECHO_EN defined, write 0x5A to 0x01 -> fx_q=0x5A the next cycle. Without the macro -> fx_q=0x00.
